// File: rtl/ss2_cobs_rx_framer.sv
// SimpleSerial v2 receive framer: COBS-decodes UART bytes, checks the trailing CRC-8 and
// streams the payload. Define SS2_RX_TIMEOUT_EN to enable the inter-byte timeout abort.
module ss2_cobs_rx_framer #(
  parameter int unsigned pMAX_FRAME = 255,
  parameter logic [7:0]  pCRC_POLY  = 8'h4D,
  parameter int unsigned pTIMEOUT   = 65535
) (
  input  logic       usb_clk,
  input  logic       reset_i,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic       frame_end,
  output logic       frame_ok,
  output logic [2:0] error_code,
  output logic [7:0] err_count,
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StCode, StData, StDiscard} state_e;

  localparam logic [2:0] ErrNone    = 3'd0;
  localparam logic [2:0] ErrShort   = 3'd1;
  localparam logic [2:0] ErrOver    = 3'd2;
  localparam logic [2:0] ErrCrc     = 3'd3;
  localparam logic [2:0] ErrTimeout = 3'd4;
  localparam logic [8:0] MaxCnt     = 9'(pMAX_FRAME);

  state_e     state_q;
  logic [7:0] code_q;
  logic [7:0] hold_q;
  logic       hold_full_q;
  logic [7:0] crc_q;
  logic [8:0] rem_q;
  logic [8:0] cnt_q;

  logic       rx_zero;
  logic       push_en;
  logic [7:0] push_byte;
  logic       over;
  logic       close_en;
  logic [2:0] close_err;
  logic       tmo_hit;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    c = crc ^ b;
    for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ pCRC_POLY) : (c << 1);
    return c;
  endfunction

`ifdef SS2_RX_TIMEOUT_EN
  localparam logic [15:0] TmoLim = 16'(pTIMEOUT);
  logic [15:0] tmr_q;

  always_ff @(posedge usb_clk) begin
    if (reset_i || rx_valid || state_q == StIdle) tmr_q <= '0;
    else                                          tmr_q <= tmr_q + 16'd1;
  end

  // A byte arriving on the expiry cycle wins over the timeout.
  assign tmo_hit = !rx_valid && (state_q != StIdle) && (tmr_q + 16'd1 == TmoLim);
`else
  logic unused_timeout;
  assign unused_timeout = ^pTIMEOUT;
  assign tmo_hit        = 1'b0;
`endif

  always_comb begin
    rx_zero   = (rx_data == 8'h00);
    // Decoded bytes: block data in DATA, the implicit zero when a new code follows a <255 block.
    push_en   = rx_valid && !rx_zero &&
                ((state_q == StData) || (state_q == StCode && code_q != 8'hFF));
    push_byte = (state_q == StData) ? rx_data : 8'h00;
    over      = push_en && (cnt_q >= MaxCnt);
    close_en  = 1'b0;
    close_err = ErrNone;
    if (tmo_hit) begin
      close_en  = 1'b1;
      close_err = ErrTimeout;
    end else if (rx_valid && rx_zero) begin
      unique case (state_q)
        StData: begin
          close_en  = 1'b1;
          close_err = ErrShort;
        end
        StCode: begin
          close_en = 1'b1;
          if (cnt_q < 9'd2)         close_err = ErrShort;
          else if (hold_q != crc_q) close_err = ErrCrc;
        end
        StDiscard: begin
          close_en  = 1'b1;
          close_err = ErrOver;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge usb_clk) begin
    if (reset_i) begin
      state_q     <= StIdle;
      code_q      <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      crc_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      dout        <= '0;
      dout_valid  <= 1'b0;
      frame_end   <= 1'b0;
      frame_ok    <= 1'b0;
      error_code  <= ErrNone;
      err_count   <= '0;
    end else begin
      dout_valid <= 1'b0;
      frame_end  <= 1'b0;
      // The hold register keeps the newest decoded byte back so the CRC byte is never emitted.
      if (push_en && !over) begin
        if (hold_full_q) begin
          dout       <= hold_q;
          dout_valid <= 1'b1;
          crc_q      <= crc8_step(crc_q, hold_q);
        end
        hold_q      <= push_byte;
        hold_full_q <= 1'b1;
        cnt_q       <= cnt_q + 9'd1;
      end
      if (close_en) begin
        frame_end  <= 1'b1;
        frame_ok   <= (close_err == ErrNone);
        error_code <= close_err;
        if (close_err != ErrNone && err_count != 8'hFF) err_count <= err_count + 8'd1;
        state_q     <= StIdle;
        code_q      <= '0;
        hold_q      <= '0;
        hold_full_q <= 1'b0;
        crc_q       <= '0;
        rem_q       <= '0;
        cnt_q       <= '0;
      end else if (rx_valid && !rx_zero) begin
        unique case (state_q)
          StIdle, StCode: begin
            if (over) begin
              state_q <= StDiscard;
            end else begin
              code_q  <= rx_data;
              rem_q   <= {1'b0, rx_data} - 9'd1;
              state_q <= (rx_data > 8'd1) ? StData : StCode;
            end
          end
          StData: begin
            if (over) begin
              state_q <= StDiscard;
            end else begin
              rem_q <= rem_q - 9'd1;
              if (rem_q == 9'd1) state_q <= StCode;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_ss2_cobs_rx_framer.sv
// Self-checking bench for ss2_cobs_rx_framer: two instances (max frame 255 and 4) share the
// same byte stream and are checked against a queue-based COBS/CRC reference model.
module tb_ss2_cobs_rx_framer;

  typedef logic [7:0] bq_t[$];

  logic       usb_clk = 1'b0;
  logic       reset_i;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] dout_w   [2];
  logic       dv_w     [2];
  logic       fe_w     [2];
  logic       fo_w     [2];
  logic [2:0] ec_w     [2];
  logic [7:0] cnt_w    [2];
  logic       busy_w   [2];

  int         tests = 0;
  int         fails = 0;
  int         fe_cnt [2] = '{0, 0};
  logic       ok_l   [2];
  logic [2:0] el     [2];
  int         ecnt   [2] = '{0, 0};
  logic [8:0] mon_q[$];

  always #5 usb_clk = ~usb_clk;

  ss2_cobs_rx_framer #(.pMAX_FRAME(255), .pCRC_POLY(8'h4D), .pTIMEOUT(100)) u_big (
    .usb_clk(usb_clk), .reset_i(reset_i), .rx_data(rx_data), .rx_valid(rx_valid),
    .dout(dout_w[0]), .dout_valid(dv_w[0]), .frame_end(fe_w[0]), .frame_ok(fo_w[0]),
    .error_code(ec_w[0]), .err_count(cnt_w[0]), .busy(busy_w[0])
  );

  ss2_cobs_rx_framer #(.pMAX_FRAME(4), .pCRC_POLY(8'h4D), .pTIMEOUT(100)) u_small (
    .usb_clk(usb_clk), .reset_i(reset_i), .rx_data(rx_data), .rx_valid(rx_valid),
    .dout(dout_w[1]), .dout_valid(dv_w[1]), .frame_end(fe_w[1]), .frame_ok(fo_w[1]),
    .error_code(ec_w[1]), .err_count(cnt_w[1]), .busy(busy_w[1])
  );

  always @(negedge usb_clk) begin
    for (int d = 0; d < 2; d++) begin
      if (dv_w[d]) mon_q.push_back({d[0], dout_w[d]});
      if (fe_w[d]) begin
        fe_cnt[d] = fe_cnt[d] + 1;
        ok_l[d]   = fo_w[d];
        el[d]     = ec_w[d];
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] crc8(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    c = crc ^ b;
    for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h4D) : (c << 1);
    return c;
  endfunction

  function automatic bq_t cobs_encode(input bq_t data);
    bq_t enc, blk;
    foreach (data[k]) begin
      if (data[k] == 8'h00) begin
        enc.push_back(8'(blk.size() + 1));
        foreach (blk[j]) enc.push_back(blk[j]);
        blk = {};
      end else begin
        blk.push_back(data[k]);
        if (blk.size() == 254) begin
          enc.push_back(8'hFF);
          foreach (blk[j]) enc.push_back(blk[j]);
          blk = {};
        end
      end
    end
    enc.push_back(8'(blk.size() + 1));
    foreach (blk[j]) enc.push_back(blk[j]);
    enc.push_back(8'h00);
    return enc;
  endfunction

  function automatic bq_t dut_bytes(input int d, input int from);
    bq_t r;
    for (int k = from; k < mon_q.size(); k++)
      if (mon_q[k][8] == d[0]) r.push_back(mon_q[k][7:0]);
    return r;
  endfunction

  // Decode a whole frame, then decide what a framer with the given limit must emit.
  task automatic model_frame(input bq_t enc, input int maxf, output bq_t emit,
                             output logic [2:0] err);
    bq_t dec;
    int i, c, n;
    bit trunc, done;
    logic [7:0] crc;
    i = 0; trunc = 0; done = 0; emit = {};
    while (enc[i] == 8'h00) i++;
    while (!done) begin
      c = enc[i]; i++;
      for (int k = 1; k < c && !trunc; k++) begin
        if (enc[i] == 8'h00) trunc = 1;
        else begin dec.push_back(enc[i]); i++; end
      end
      if (trunc || enc[i] == 8'h00) done = 1;
      else if (c < 255) dec.push_back(8'h00);
    end
    if (dec.size() > maxf) begin
      err = 3'd2; n = maxf - 1;
    end else begin
      n = (dec.size() > 0) ? dec.size() - 1 : 0;
      if (trunc || dec.size() < 2) err = 3'd1;
      else begin
        crc = 8'h00;
        for (int k = 0; k < n; k++) crc = crc8(crc, dec[k]);
        err = (dec[n] == crc) ? 3'd0 : 3'd3;
      end
    end
    for (int k = 0; k < n; k++) emit.push_back(dec[k]);
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge usb_clk); #1; end
  endtask

  task automatic drive_frame(input bq_t enc, input int gapmax);
    foreach (enc[k]) begin
      rx_data = enc[k]; rx_valid = 1'b1;
      step(1);
      rx_valid = 1'b0;
      step($urandom_range(gapmax, 0));
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    step(3);
    for (int d = 0; d < 2; d++) begin
      tests++;
      if ({dout_w[d], dv_w[d], fe_w[d], fo_w[d], ec_w[d], cnt_w[d], busy_w[d]} !== 22'd0) begin
        fails++;
        $display("FAIL reset dut%0d outputs got %h want 0", d,
                 {dout_w[d], dv_w[d], fe_w[d], fo_w[d], ec_w[d], cnt_w[d], busy_w[d]});
      end
    end
    reset_i = 1'b0;
    step(2);
  endtask

  task automatic test_vectors();
    bq_t enc, exp_q, got;
    logic [2:0] exp_err;
    int base_fe [2];
    int base_m;
    bit bad;
    base_fe = fe_cnt;
    enc = '{8'h00, 8'h00, 8'h00};
    drive_frame(enc, 1);
    step(2);
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (fe_cnt[d] !== base_fe[d] || busy_w[d] !== 1'b0) begin
        fails++;
        $display("FAIL idle_delim dut%0d frame_end pulses %0d busy %b want 0 0", d,
                 fe_cnt[d] - base_fe[d], busy_w[d]);
      end
    end
    for (int v = 0; v < 5; v++) begin
      case (v)
        0:       enc = '{8'h03, 8'h01, 8'h4D, 8'h00};
        1:       enc = '{8'h01, 8'h01, 8'h01, 8'h00};
        2:       enc = '{8'h03, 8'h01, 8'h4C, 8'h00};
        3:       enc = '{8'h04, 8'h01, 8'h00};
        default: enc = '{8'h06, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h00};
      endcase
      base_fe = fe_cnt; base_m = mon_q.size();
      drive_frame(enc, v % 2);
      step(2);
      for (int d = 0; d < 2; d++) begin
        model_frame(enc, (d == 0) ? 255 : 4, exp_q, exp_err);
        got = dut_bytes(d, base_m);
        tests++;
        if (fe_cnt[d] - base_fe[d] !== 1) begin
          fails++;
          $display("FAIL vec%0d dut%0d frame_end pulses got %0d want 1", v, d,
                   fe_cnt[d] - base_fe[d]);
        end
        bad = (got.size() != exp_q.size());
        for (int k = 0; k < got.size() && !bad; k++) bad = (got[k] !== exp_q[k]);
        tests++;
        if (bad) begin
          fails++;
          $display("FAIL vec%0d dut%0d payload got %p want %p", v, d, got, exp_q);
        end
        tests++;
        if (ok_l[d] !== (exp_err == 3'd0) || el[d] !== exp_err) begin
          fails++;
          $display("FAIL vec%0d dut%0d status got ok=%b code=%0d want ok=%b code=%0d", v, d,
                   ok_l[d], el[d], exp_err == 3'd0, exp_err);
        end
        if (exp_err != 3'd0 && ecnt[d] < 255) ecnt[d]++;
        tests++;
        if (cnt_w[d] !== 8'(ecnt[d])) begin
          fails++;
          $display("FAIL vec%0d dut%0d err_count got %0d want %0d", v, d, cnt_w[d], ecnt[d]);
        end
      end
    end
  endtask

  task automatic test_random(input int nframes, input int gapmax, input string name);
    bq_t data, enc, exp_q, got;
    logic [2:0] exp_err;
    logic [7:0] crc;
    int base_fe [2];
    int base_m, len, zp, mode, drop;
    bit bad;
    for (int f = 0; f < nframes; f++) begin
      data = {};
      len  = ($urandom_range(9, 0) == 0) ? $urandom_range(300, 250) : $urandom_range(12, 0);
      zp   = $urandom_range(1, 0) ? 4 : 0;
      for (int k = 0; k < len; k++)
        data.push_back((zp != 0 && $urandom_range(zp - 1, 0) == 0) ? 8'h00
                                                                    : 8'($urandom_range(255, 1)));
      crc = 8'h00;
      foreach (data[k]) crc = crc8(crc, data[k]);
      mode = $urandom_range(3, 0);
      if (mode == 1) crc = crc ^ 8'($urandom_range(255, 1));
      data.push_back(crc);
      enc = cobs_encode(data);
      if (mode == 2 && enc.size() > 2) begin
        drop = $urandom_range(enc.size() - 2, 1);
        repeat (drop) enc.delete(enc.size() - 2);
      end
      if ($urandom_range(3, 0) == 0) enc.push_front(8'h00);
      base_fe = fe_cnt; base_m = mon_q.size();
      drive_frame(enc, gapmax);
      step(2);
      for (int d = 0; d < 2; d++) begin
        model_frame(enc, (d == 0) ? 255 : 4, exp_q, exp_err);
        got = dut_bytes(d, base_m);
        tests++;
        if (fe_cnt[d] - base_fe[d] !== 1) begin
          fails++;
          $display("FAIL %s%0d dut%0d frame_end pulses got %0d want 1", name, f, d,
                   fe_cnt[d] - base_fe[d]);
        end
        bad = (got.size() != exp_q.size());
        for (int k = 0; k < got.size() && !bad; k++) bad = (got[k] !== exp_q[k]);
        tests++;
        if (bad) begin
          fails++;
          $display("FAIL %s%0d dut%0d payload got %0d bytes want %0d bytes", name, f, d,
                   got.size(), exp_q.size());
        end
        tests++;
        if (ok_l[d] !== (exp_err == 3'd0) || el[d] !== exp_err) begin
          fails++;
          $display("FAIL %s%0d dut%0d status got ok=%b code=%0d want ok=%b code=%0d", name, f,
                   d, ok_l[d], el[d], exp_err == 3'd0, exp_err);
        end
        if (exp_err != 3'd0 && ecnt[d] < 255) ecnt[d]++;
        tests++;
        if (cnt_w[d] !== 8'(ecnt[d])) begin
          fails++;
          $display("FAIL %s%0d dut%0d err_count got %0d want %0d", name, f, d, cnt_w[d],
                   ecnt[d]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    test_random(20, 0, "back_to_back");
  endtask

  task automatic test_saturation();
    bq_t enc;
    enc = '{8'h04, 8'h01, 8'h00};
    for (int f = 0; f < 260; f++) drive_frame(enc, 0);
    step(2);
    for (int d = 0; d < 2; d++) begin
      ecnt[d] = (ecnt[d] + 260 > 255) ? 255 : ecnt[d] + 260;
      tests++;
      if (cnt_w[d] !== 8'(ecnt[d])) begin
        fails++;
        $display("FAIL saturation dut%0d err_count got %0d want %0d", d, cnt_w[d], ecnt[d]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    bq_t enc, got;
    int base_fe [2];
    int base_m;
    base_fe = fe_cnt;
    enc = '{8'h03, 8'h01};
    drive_frame(enc, 0);
    reset_i = 1'b1;
    step(1);
    reset_i = 1'b0;
    step(2);
    ecnt = '{0, 0};
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (fe_cnt[d] !== base_fe[d] || busy_w[d] !== 1'b0 || cnt_w[d] !== 8'd0) begin
        fails++;
        $display("FAIL mid_reset dut%0d pulses=%0d busy=%b err_count=%0d want 0 0 0", d,
                 fe_cnt[d] - base_fe[d], busy_w[d], cnt_w[d]);
      end
    end
    base_fe = fe_cnt; base_m = mon_q.size();
    enc = '{8'h03, 8'h01, 8'h4D, 8'h00};
    drive_frame(enc, 0);
    step(2);
    for (int d = 0; d < 2; d++) begin
      got = dut_bytes(d, base_m);
      tests++;
      if (fe_cnt[d] - base_fe[d] !== 1 || ok_l[d] !== 1'b1 || el[d] !== 3'd0) begin
        fails++;
        $display("FAIL after_reset dut%0d pulses=%0d ok=%b code=%0d want 1 1 0", d,
                 fe_cnt[d] - base_fe[d], ok_l[d], el[d]);
      end
      tests++;
      if (got.size() != 1 || got[0] !== 8'h01) begin
        fails++;
        $display("FAIL after_reset dut%0d payload got %p want '{1}", d, got);
      end
    end
  endtask

  task automatic test_timeout();
    bq_t enc;
    int base_fe [2];
    base_fe = fe_cnt;
    enc = '{8'h03, 8'h01};
    drive_frame(enc, 0);
`ifdef SS2_RX_TIMEOUT_EN
    step(60);
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (fe_cnt[d] !== base_fe[d] || busy_w[d] !== 1'b1) begin
        fails++;
        $display("FAIL early_timeout dut%0d pulses=%0d busy=%b want 0 1", d,
                 fe_cnt[d] - base_fe[d], busy_w[d]);
      end
    end
    step(45);
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (fe_cnt[d] - base_fe[d] !== 1 || ok_l[d] !== 1'b0 || el[d] !== 3'd4) begin
        fails++;
        $display("FAIL timeout dut%0d pulses=%0d ok=%b code=%0d want 1 0 4", d,
                 fe_cnt[d] - base_fe[d], ok_l[d], el[d]);
      end
      if (ecnt[d] < 255) ecnt[d]++;
      tests++;
      if (cnt_w[d] !== 8'(ecnt[d])) begin
        fails++;
        $display("FAIL timeout dut%0d err_count got %0d want %0d", d, cnt_w[d], ecnt[d]);
      end
    end
`else
    step(200);
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (fe_cnt[d] !== base_fe[d] || busy_w[d] !== 1'b1) begin
        fails++;
        $display("FAIL stall dut%0d pulses=%0d busy=%b want 0 1", d,
                 fe_cnt[d] - base_fe[d], busy_w[d]);
      end
    end
    enc = '{8'h4D, 8'h00};
    drive_frame(enc, 0);
    step(2);
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (fe_cnt[d] - base_fe[d] !== 1 || ok_l[d] !== 1'b1 || el[d] !== 3'd0) begin
        fails++;
        $display("FAIL stall_resume dut%0d pulses=%0d ok=%b code=%0d want 1 1 0", d,
                 fe_cnt[d] - base_fe[d], ok_l[d], el[d]);
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random(40, 3, "random");
    test_back_to_back();
    test_saturation();
    test_reset_mid_frame();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
